// File: rtl/kb_code_arbiter.sv
// rtl/kb_code_arbiter.sv - round-robin arbiter sharing the keyboard code buffer between two consumers
module kb_code_arbiter #(
    parameter int TIMEOUT = 1000,
    parameter int TO_W    = 10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] key_code,
    input  logic       kb_buf_empty,
    output logic       rd_key_code,
    input  logic       req0,
    input  logic       req1,
    input  logic       ack0,
    input  logic       ack1,
    output logic       gnt0,
    output logic       gnt1,
    output logic [7:0] code_out,
    output logic       timeout_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        POP   = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic            owner, owner_nx;
    logic            last_gnt, last_gnt_nx;
    logic [7:0]      code_nx;
    logic [TO_W-1:0] cnt, cnt_nx;
    logic            terr_nx;
    logic            own_req, own_ack;

    // Only the current grantee's req/ack matter; the other ack is ignored.
    assign own_req = owner ? req1 : req0;
    assign own_ack = owner ? ack1 : ack0;

    always_comb begin
        state_nx    = state;
        owner_nx    = owner;
        last_gnt_nx = last_gnt;
        code_nx     = code_out;
        cnt_nx      = cnt;
        terr_nx     = 1'b0;
        case (state)
            IDLE: begin
                if (!kb_buf_empty && (req0 || req1)) begin
                    state_nx = GRANT;
                    code_nx  = key_code;
                    cnt_nx   = '0;
                    owner_nx = (req0 && req1) ? ~last_gnt : req1;
                end
            end
            GRANT: begin
                if (own_ack) begin
                    state_nx    = POP;
                    last_gnt_nx = owner;
                end else if (!own_req) begin
                    state_nx = IDLE;
                end else if (cnt == TO_W'(TIMEOUT - 1)) begin
                    state_nx    = IDLE;
                    terr_nx     = 1'b1;
                    last_gnt_nx = owner;
                end else begin
                    cnt_nx = cnt + TO_W'(1);
                end
            end
            POP:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            owner       <= 1'b0;
            last_gnt    <= 1'b1;
            code_out    <= 8'h00;
            cnt         <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nx;
            owner       <= owner_nx;
            last_gnt    <= last_gnt_nx;
            code_out    <= code_nx;
            cnt         <= cnt_nx;
            timeout_err <= terr_nx;
        end
    end

    // Grants and the pop strobe decode straight from registered state, so they are glitch-free.
    assign gnt0        = (state == GRANT) && !owner;
    assign gnt1        = (state == GRANT) && owner;
    assign rd_key_code = (state == POP);

endmodule

// File: doc/kb_code_arbiter.md
Name: kb_code_arbiter

Overview:
Shares the keyboard scan-code buffer (the kb_code FIFO output: key_code / kb_buf_empty / rd_key_code) between two consumers. Example consumers are a display/Fibonacci control path and a command decoder. The block grants the head-of-buffer code to one requester at a time using round-robin, and holds the code stable until that requester acknowledges. It then pops the buffer with a single-cycle rd_key_code pulse. A stalled consumer is released by a timeout without consuming the code.

Parameters:
TIMEOUT, 1000, cycles a grant may stay unacknowledged before it is withdrawn (must be >=2)
TO_W, 10, width of the timeout counter (2^TO_W >= TIMEOUT)

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
key_code  input  8  head-of-buffer scan code (first-word-fall-through, valid when kb_buf_empty=0)
kb_buf_empty  input  1  buffer empty flag
rd_key_code  output  1  one-cycle pop strobe to buffer
req0  input  1  requester 0 wants a code (level)
req1  input  1  requester 1 wants a code (level)
ack0  input  1  requester 0 has taken code (single-cycle)
ack1  input  1  requester 1 has taken code
gnt0  output  1  code presented to requester 0 (level)
gnt1  output  1  code presented to requester 1
code_out  output  8  registered code shown to the granted requester
timeout_err  output  1  one-cycle pulse when a grant is withdrawn by timeout

Behaviour:
- Reset (async, reset_n=0): state=IDLE. gnt0=gnt1=0, rd_key_code=0, timeout_err=0, code_out=8'h00, timeout counter=0. The priority pointer last_gnt=1, so requester 0 wins the first tie.
- FSM has three states: IDLE, GRANT, POP.
- IDLE:
  - If kb_buf_empty=0 and (req0|req1), select the winner:
    - if only one requester is active, that requester wins;
    - if both are active, the requester not equal to last_gnt wins.
  - On selection, latch key_code into code_out, set the winner's gnt, clear the counter, and go to GRANT.
  - If the buffer is empty or no request is active, stay in IDLE.
- GRANT (exactly one gnt high, code_out constant):
  - Ack of the granted requester has priority over all other GRANT conditions. On it: clear gnt, set last_gnt=grantee, go to POP.
  - Granted requester's req falls without ack: clear gnt and go to IDLE without popping. last_gnt is unchanged.
  - Counter reaches TIMEOUT-1 without ack: clear gnt, pulse timeout_err for 1 cycle, set last_gnt=grantee, go to IDLE without popping. The code stays in the buffer.
  - Otherwise, increment the counter.
  - Ack from the non-granted requester is ignored in every state.
- POP: rd_key_code=1 for exactly this cycle, then go to IDLE. The buffer updates on this edge, so IDLE evaluates the new kb_buf_empty/key_code.
- Latency:
  - req with non-empty buffer sampled in IDLE at edge n -> gnt/code_out valid after edge n.
  - ack at cycle m -> gnt low and rd_key_code high in cycle m+1.
  - Earliest next grant is visible in cycle m+3.
- Invariants:
  - gnt0 & gnt1 is never 1.
  - rd_key_code is never asserted while kb_buf_empty=1.
  - rd_key_code is at most one pulse per ack.
  - code_out changes only on entry to GRANT.
- Reset asserted mid-GRANT or mid-POP returns to reset values immediately. No pop is issued after reset is released.

Test Plan:
- Single requester: buffer holds 8'h1C, req0=1 -> gnt0=1, code_out=8'h1C next cycle. ack0 pulse -> rd_key_code=1 for one cycle, gnt0=0, and the buffer advances.
- Contention: buffer holds 8'h1C, 8'h32, 8'h21, 8'h23 and req0=req1=1 held, each ack given 2 cycles after grant -> grants alternate 0,1,0,1 with codes 1C,32,21,23. Exactly 4 rd_key_code pulses occur.
- Timeout: TIMEOUT=8, req0=1, no ack -> gnt0 drops after 8 grant cycles, timeout_err pulses once, no rd_key_code. With req1 also high, the next grant goes to requester 1 with the same code (8'h1C).
- Request withdrawal: grant to requester 1, then req1 drops -> gnt1=0 next cycle, no pop, same code re-offered to requester 0 if req0=1. A stray ack0 during gnt1 is ignored.
- Empty buffer: kb_buf_empty=1 with req0=req1=1 for 20 cycles -> no gnt and no rd_key_code. When a code is written, a grant appears within 2 cycles.
- Reset mid-operation: drive reset_n low during GRANT -> all outputs 0 asynchronously. After release with req0=1, gnt0 is re-issued and no pop occurs without an ack.
